// File: rtl/uart1655_axil_tx_if.sv
// Byte handshake between the TX holding register/FIFO and the serializer.
// The master offers a byte; the slave (serializer) accepts it on valid && ready.
interface uart1655_axil_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart1655_axil_tx.sv
// 16550-style UART transmit serializer: start, 5-8 data bits LSB first, optional parity,
// 1/1.5/2 stop bits, timed by a 16x baud tick. Frame config is captured when a byte is accepted.
module uart1655_axil_tx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic [1:0]           wlen,
    input  logic                 stb,
    input  logic                 pen,
    input  logic                 eps,
    input  logic                 sp,
    input  logic                 brk,
    uart1655_axil_tx_if.slave    tx,
    output logic                 txd,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(2 * OVERSAMPLE);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] tick_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic [1:0]      wlen_q;
    logic            stb_q;
    logic            pen_q;
    logic            parity_q;
    logic            line_q;
    logic            txd_q;
    logic            ready_q;
    logic            busy_q;

    logic [7:0]      data_mask;
    logic            par_bit;
    logic [CntW-1:0] bit_last;
    logic            bit_done;

    // Parity over the active bits only, resolved at acceptance so eps/sp need not be kept.
    assign data_mask = 8'hFF >> (2'd3 - wlen);
    assign par_bit   = sp ? ~eps : (eps ? ^(tx.tx_data & data_mask) : ~^(tx.tx_data & data_mask));

    always_comb begin
        bit_last = CntW'(OVERSAMPLE - 1);
        if (state_q == StStop && stb_q) begin
            bit_last = (wlen_q == 2'd0) ? CntW'(OVERSAMPLE * 3 / 2 - 1)
                                        : CntW'(2 * OVERSAMPLE - 1);
        end
    end

    assign bit_done = tick && (tick_cnt_q == bit_last);

    // line_q is the nominal bit level; txd_q is that level gated by the live break control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wlen_q     <= '0;
            stb_q      <= 1'b0;
            pen_q      <= 1'b0;
            parity_q   <= 1'b0;
            line_q     <= 1'b1;
            txd_q      <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            txd_q <= ~brk & line_q;
            if (state_q != StIdle && tick) begin
                tick_cnt_q <= bit_done ? '0 : tick_cnt_q + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tx.tx_valid && ready_q) begin
                        shift_q    <= tx.tx_data;
                        wlen_q     <= wlen;
                        stb_q      <= stb;
                        pen_q      <= pen;
                        parity_q   <= par_bit;
                        tick_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        line_q     <= 1'b0;
                        txd_q      <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        line_q  <= shift_q[0];
                        txd_q   <= ~brk & shift_q[0];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == ({1'b0, wlen_q} + 3'd4)) begin
                            bit_cnt_q <= '0;
                            if (pen_q) begin
                                line_q  <= parity_q;
                                txd_q   <= ~brk & parity_q;
                                state_q <= StParity;
                            end else begin
                                line_q  <= 1'b1;
                                txd_q   <= ~brk;
                                state_q <= StStop;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            line_q    <= shift_q[1];
                            txd_q     <= ~brk & shift_q[1];
                        end
                    end
                end
                StParity: begin
                    if (bit_done) begin
                        line_q  <= 1'b1;
                        txd_q   <= ~brk;
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        line_q  <= 1'b1;
                        txd_q   <= ~brk;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign txd         = txd_q;
    assign busy        = busy_q;

endmodule
